// File: rtl/btn_pkg.sv
// Shared constants and types for the keypad button conditioning front end.
// Defaults target the 100 MHz board clock.
package btn_pkg;

   localparam int NUM_BTN  = 5;

   localparam int BTN_0    = 0;
   localparam int BTN_1    = 1;
   localparam int BTN_UP   = 2;
   localparam int BTN_DOWN = 3;
   localparam int BTN_4    = 4;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
   localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
   localparam int DEF_REPEAT_RATE     = 20000000;  // 200 ms
   localparam logic [NUM_BTN-1:0] DEF_REPEAT_MASK =
      NUM_BTN'((1 << BTN_UP) | (1 << BTN_DOWN));

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      RPT
   } rpt_state_e;

endpackage

// File: rtl/btn_debounce_1b.sv
// One button: 2-flop synchroniser, debounce counter, stable level flop
// and a rise strobe that is valid in the cycle before stable goes high.
module btn_debounce_1b
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Combinational so the top can register its pulse on the same edge stable rises.
   assign rise = sync2 && !stable && (cnt == CNT_MAX);

endmodule

// File: rtl/btn_conditioner.sv
// Keypad button conditioner: per-bit debounce, one-cycle press pulses,
// and auto-repeat pulses for the buttons selected by REPEAT_MASK.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int                 REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int                 REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(RPT_MAX);
   localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

   logic [NUM_BTN-1:0] stable;
   logic [NUM_BTN-1:0] rise;

   assign btn_level = stable;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce_1b #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .btn_raw (btn_raw[i]),
         .stable  (stable[i]),
         .rise    (rise[i])
      );

      if (REPEAT_MASK[i]) begin : g_rpt
         rpt_state_e    state_q, state_d;
         logic [RW-1:0] cnt_q, cnt_d;
         logic          pulse_q, pulse_d;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q <= IDLE;
               cnt_q   <= '0;
               pulse_q <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               pulse_q <= pulse_d;
            end
         end

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
               IDLE: begin
                  if (rise[i]) begin
                     pulse_d = 1'b1;
                     cnt_d   = DELAY_LOAD;
                     state_d = DELAY;
                  end
               end
               DELAY, RPT: begin
                  // Release aborts the repeat sequence without a final pulse.
                  if (!stable[i]) begin
                     state_d = IDLE;
                  end else if (cnt_q == '0) begin
                     pulse_d = 1'b1;
                     cnt_d   = RATE_LOAD;
                     state_d = RPT;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end

         assign btn_pulse[i] = pulse_q;
      end else begin : g_norpt
         logic pulse_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) pulse_q <= 1'b0;
            else     pulse_q <= rise[i];
         end

         assign btn_pulse[i] = pulse_q;
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and random checks of btn_conditioner against a sample-history
// reference model (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
module tb_btn_conditioner;
   import btn_pkg::*;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 3;
   localparam logic [NUM_BTN-1:0] MASK = 5'b01100;

   logic               clk;
   logic               rst;
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_pulse;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR),
      .REPEAT_MASK     (MASK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: hist[k] is the raw value sampled k edges ago.
   logic [NUM_BTN-1:0] hist [0:D+1];
   logic [NUM_BTN-1:0] m_stable;
   logic [NUM_BTN-1:0] exp_pulse;
   int                 last_rise [NUM_BTN];
   int                 npulse    [NUM_BTN];
   int                 n;

   task automatic model_reset();
      for (int unsigned j = 0; j < D + 2; j++) hist[j] = '0;
      m_stable  = '0;
      exp_pulse = '0;
      n         = 0;
      for (int unsigned b = 0; b < NUM_BTN; b++) last_rise[b] = 0;
   endtask

   task automatic clear_counts();
      for (int unsigned b = 0; b < NUM_BTN; b++) npulse[b] = 0;
   endtask

   // A level is accepted once the synchronised value (raw two edges ago) has
   // disagreed with the stable level on D consecutive edges.
   task automatic model_step(input logic [NUM_BTN-1:0] r);
      logic [NUM_BTN-1:0] prev;
      logic               flip;
      int                 k;
      prev = m_stable;
      for (int unsigned j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0]   = r;
      exp_pulse = '0;
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
         flip = 1'b1;
         for (int unsigned j = 2; j < D + 2; j++)
            if (hist[j][b] == prev[b]) flip = 1'b0;
         if (flip) m_stable[b] = ~prev[b];
         if (flip && !prev[b]) begin
            exp_pulse[b] = 1'b1;
            last_rise[b] = n;
         end else if (MASK[b] && prev[b]) begin
            k = n - last_rise[b];
            if (k == RD || (k > RD && (k - RD) % RR == 0)) exp_pulse[b] = 1'b1;
         end
      end
      n++;
   endtask

   task automatic check(input string tag, input logic [NUM_BTN-1:0] got,
                        input logic [NUM_BTN-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic [NUM_BTN-1:0] r);
      btn_raw = r;
      @(posedge clk);
      model_step(r);
      #1;
      check("level", btn_level, m_stable);
      check("pulse", btn_pulse, exp_pulse);
      for (int unsigned b = 0; b < NUM_BTN; b++)
         if (btn_pulse[b] === 1'b1) npulse[b]++;
   endtask

   task automatic hold(input logic [NUM_BTN-1:0] r, input int cycles);
      repeat (cycles) cycle(r);
   endtask

   logic [NUM_BTN-1:0] rnd;

   initial begin
      rst     = 1'b1;
      btn_raw = '0;
      model_reset();
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      check("reset_level", btn_level, '0);
      check("reset_pulse", btn_pulse, '0);
      #2 rst = 1'b0;

      // Clean press on button 0: first pulse after edge 5 only.
      clear_counts();
      hold(5'b00001, 5);
      cycle(5'b00001);
      check("clean_edge5", btn_pulse, 5'b00001);
      hold(5'b00001, 4);
      check_int("clean_count", npulse[BTN_0], 1);
      hold('0, 8);

      // Bounce on button 1 then steady press.
      clear_counts();
      cycle(5'b00010); cycle('0); cycle(5'b00010); cycle('0);
      check_int("bounce_none", npulse[BTN_1], 0);
      hold(5'b00010, 5);
      cycle(5'b00010);
      check("bounce_edge5", btn_pulse, 5'b00010);
      hold(5'b00010, 3);
      check_int("bounce_count", npulse[BTN_1], 1);
      hold('0, 8);

      // Auto-repeat on up, none on button 0: edges 5,15,18,21,24,27.
      clear_counts();
      hold(5'b00101, 30);
      check_int("rpt_up_count", npulse[BTN_UP], 6);
      check_int("rpt_b0_count", npulse[BTN_0], 1);
      hold('0, 10);

      // Down released early enough that stable falls before the delay expires.
      clear_counts();
      hold(5'b01000, 9);
      hold('0, 12);
      check_int("rel_delay_count", npulse[BTN_DOWN], 1);

      // Up and down together.
      clear_counts();
      hold(5'b01100, 5);
      cycle(5'b01100);
      check("simul_edge5", btn_pulse, 5'b01100);
      hold(5'b01100, 2);
      check_int("simul_up", npulse[BTN_UP], 1);
      hold('0, 8);

      // Asynchronous reset while up is auto-repeating.
      hold(5'b00100, 20);
      #2 rst = 1'b1;
      #1;
      check("arst_level", btn_level, '0);
      check("arst_pulse", btn_pulse, '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("arst_hold_level", btn_level, '0);
      rst = 1'b0;
      clear_counts();
      hold(5'b00100, 5);
      cycle(5'b00100);
      check("arst_repress", btn_pulse, 5'b00100);
      hold(5'b00100, 2);
      hold('0, 8);

      // Random bouncing on all buttons.
      rnd = '0;
      repeat (500) begin
         for (int unsigned b = 0; b < NUM_BTN; b++)
            if ($urandom_range(0, 4) == 0) rnd[b] = ~rnd[b];
         cycle(rnd);
      end
      hold('0, 20);
      check("final_level", btn_level, '0);
      check_int("idx_btn4", BTN_4 + 0 * npulse[BTN_4], 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
